// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_capture_pkg;

  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_DUTY_W = 8;
  localparam int unsigned SYNC_DEPTH = 2;
  localparam int unsigned FILT_LEN   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_div.sv
// Serial restoring divider: q = floor(num * 2^DUTY_W / den), one quotient bit per cycle.
// The first quotient bit is produced on the start cycle itself.
module pwm_div #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num,
  input  logic [CNT_W-1:0]  den,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] q
);

  localparam int unsigned STEP_W = $clog2(DUTY_W + 1);

  logic [CNT_W-1:0]  rem_q;
  logic [CNT_W-1:0]  den_q;
  logic [STEP_W-1:0] step_q;
  logic [CNT_W-1:0]  rem_in;
  logic [CNT_W-1:0]  den_in;
  logic [CNT_W:0]    rem_sh;
  logic [CNT_W-1:0]  rem_nx;
  logic              bit_c;
  logic              go_c;

  assign go_c = start & ~busy;

  // One restoring step; num < den keeps the shifted remainder within CNT_W+1 bits.
  always_comb begin
    rem_in = go_c ? num : rem_q;
    den_in = go_c ? den : den_q;
    rem_sh = {rem_in, 1'b0};
    bit_c  = (rem_sh >= {1'b0, den_in});
    rem_nx = bit_c ? CNT_W'(rem_sh - {1'b0, den_in}) : rem_sh[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      rem_q  <= '0;
      den_q  <= '0;
      q      <= '0;
      step_q <= '0;
    end else begin
      done <= 1'b0;
      if (go_c) begin
        rem_q  <= rem_nx;
        den_q  <= den;
        q      <= DUTY_W'(bit_c);
        step_q <= STEP_W'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        rem_q  <= rem_nx;
        q      <= DUTY_W'({q, bit_c});
        step_q <= step_q + STEP_W'(1);
        if (step_q == STEP_W'(DUTY_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures period/high time of an async PWM line and reports an 8-bit-scale duty.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int unsigned CNT_W  = pwm_capture_pkg::DEF_CNT_W,
  parameter int unsigned DUTY_W = pwm_capture_pkg::DEF_DUTY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high,
  output logic              valid,
  output logic              timeout
);

  import pwm_capture_pkg::*;

  state_t            state_q, state_n;
  logic [SYNC_DEPTH-1:0] sync_q;
  logic              s_raw, s, s_d;
  logic              rise, fall;
  logic [CNT_W-1:0]  pcnt_q, hcnt_q;
  logic [CNT_W-1:0]  per_l, high_l;
  logic              load_c, start_c, tmo_c;
  logic              div_busy, div_done;
  logic [DUTY_W-1:0] div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= SYNC_DEPTH'({sync_q, pwm_in});
      s_d    <= s;
    end
  end

  assign s_raw = sync_q[SYNC_DEPTH-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned HIST_W = FILT_LEN - 1;
  logic [HIST_W-1:0] hist_q;
  logic              s_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= '0;
      s_hold_q <= 1'b0;
    end else begin
      hist_q   <= HIST_W'({hist_q, s_raw});
      s_hold_q <= s;
    end
  end

  // Follow the input only after FILT_LEN identical samples, otherwise hold.
  always_comb begin
    s = s_hold_q;
    if (&{hist_q, s_raw}) s = 1'b1;
    else if (~|{hist_q, s_raw}) s = 1'b0;
  end
`else
  assign s = s_raw;
`endif

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    load_c  = 1'b0;
    start_c = 1'b0;
    tmo_c   = 1'b0;
    if (state_q != ST_IDLE && (&pcnt_q)) begin
      tmo_c   = 1'b1;
      state_n = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rise) begin
          load_c  = 1'b1;
          state_n = ST_HIGH;
        end
        ST_HIGH: if (fall) state_n = ST_LOW;
        ST_LOW: if (rise) begin
          load_c  = 1'b1;
          start_c = ~div_busy;
          state_n = ST_HIGH;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Saturating period / high-time counters, restarted on every accepted rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      hcnt_q <= '0;
    end else if (load_c) begin
      pcnt_q <= CNT_W'(1);
      hcnt_q <= CNT_W'(1);
    end else if (state_q != ST_IDLE) begin
      if (!(&pcnt_q))     pcnt_q <= pcnt_q + CNT_W'(1);
      if (s && !(&hcnt_q)) hcnt_q <= hcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_l  <= '0;
      high_l <= '0;
    end else if (start_c) begin
      per_l  <= pcnt_q;
      high_l <= hcnt_q;
    end
  end

  pwm_div #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .num   (hcnt_q),
    .den   (pcnt_q),
    .abort (tmo_c),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q)
  );

  // Timeout takes priority over a divider completing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty    <= '0;
      period  <= '0;
      high    <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (tmo_c) begin
        duty    <= {DUTY_W{s}};
        period  <= '0;
        high    <= '0;
        timeout <= 1'b1;
        valid   <= 1'b1;
      end else if (div_done) begin
        duty    <= div_q;
        period  <= per_l;
        high    <= high_l;
        timeout <= 1'b0;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=8): checks measurements, latency, timeout and reset.
module tb_pwm_capture;

  localparam int CW = 8;
  localparam int DW = 8;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 11;
`endif
  localparam int TMO_LAT = LAT + 247;

  typedef struct {
    int cyc;
    int duty;
    int per;
    int hi;
    int tmo;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_in = 1'b0;
  logic [DW-1:0] duty;
  logic [CW-1:0] period;
  logic [CW-1:0] high;
  logic          valid;
  logic          timeout;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t evq[$];
  int  rt[6];
  int  r1, r2, r3;

  pwm_capture #(.CNT_W(CW), .DUTY_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .pwm_in  (pwm_in),
    .duty    (duty),
    .period  (period),
    .high    (high),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (valid === 1'b1)
      evq.push_back('{cyc, int'(duty), int'(period), int'(high), int'(timeout)});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    evq.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_count(input string tag, input int exp);
    chk(tag, 32'(evq.size()), 32'(exp));
  endtask

  task automatic expect_ev(input string tag, input int ecyc, input int ed,
                           input int ep, input int eh, input int et);
    ev_t e;
    chk({tag, "_present"}, 32'(evq.size() != 0), 32'd1);
    if (evq.size() != 0) begin
      e = evq.pop_front();
      chk({tag, "_cyc"}, e.cyc, ecyc);
      chk({tag, "_duty"}, e.duty, ed);
      chk({tag, "_period"}, e.per, ep);
      chk({tag, "_high"}, e.hi, eh);
      chk({tag, "_timeout"}, e.tmo, et);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_duty"}, 32'(duty), 32'd0);
    chk({tag, "_period"}, 32'(period), 32'd0);
    chk({tag, "_high"}, 32'(high), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_outputs_zero("rst");

    // 3 high / 5 low: first rise discarded, then one result per period
    drive(1'b0, 4);
    for (int i = 0; i < 6; i++) begin
      rt[i] = cyc;
      drive(1'b1, 3);
      drive(1'b0, 5);
    end
    drive(1'b0, 20);
    chk_count("a_count", 5);
    for (int i = 1; i < 6; i++)
      expect_ev($sformatf("a%0d", i), rt[i] + LAT, 96, 8, 3, 0);

    // 1 high / 15 low
    do_reset();
    drive(1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      rt[i] = cyc;
      drive(1'b1, 1);
      drive(1'b0, 15);
    end
    drive(1'b0, 20);
`ifdef PWM_CAPTURE_FILTER_EN
    chk_count("b_count_filtered", 0);
`else
    chk_count("b_count", 3);
    for (int i = 1; i < 4; i++)
      expect_ev($sformatf("b%0d", i), rt[i] + LAT, 16, 16, 1, 0);
`endif

    // Input stuck high after one measurement -> timeout, then recovery
    do_reset();
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 5);
    r1 = cyc;
    drive(1'b1, 300);
    chk_count("c_count", 2);
    expect_ev("c_meas", r1 + LAT, 96, 8, 3, 0);
    expect_ev("c_tmo", r1 + TMO_LAT, 255, 0, 0, 1);
    chk("c_tmo_level", 32'(timeout), 32'd1);
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 5);
    r2 = cyc;
    chk("c_tmo_held", 32'(timeout), 32'd1);
    drive(1'b1, 3);
    drive(1'b0, 20);
    chk_count("c_recover_count", 1);
    expect_ev("c_recover", r2 + LAT, 96, 8, 3, 0);
    chk("c_tmo_cleared", 32'(timeout), 32'd0);

    // 1/1 wave: periods completing while the divider is busy are dropped
    do_reset();
    drive(1'b0, 4);
    r1 = cyc;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    drive(1'b0, 20);
`ifdef PWM_CAPTURE_FILTER_EN
    chk_count("d_count_filtered", 0);
`else
    chk_count("d_count", 3);
    expect_ev("d0", r1 + 2 + LAT, 128, 2, 1, 0);
    expect_ev("d1", r1 + 10 + LAT, 128, 2, 1, 0);
    expect_ev("d2", r1 + 18 + LAT, 128, 2, 1, 0);
`endif

    // Reset while a division is in flight
    do_reset();
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 5);
    r1 = cyc;
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outputs_zero("e_midrst");
    drive(1'b0, 20);
    chk_count("e_count", 1);
    expect_ev("e_before", r1 + LAT, 96, 8, 3, 0);
    drive(1'b1, 3);
    drive(1'b0, 5);
    r3 = cyc;
    drive(1'b1, 3);
    drive(1'b0, 20);
    chk_count("e_fresh_count", 1);
    expect_ev("e_fresh", r3 + LAT, 96, 8, 3, 0);

    // 4/4 wave, preceded by 2-cycle glitches when the filter is built in
    do_reset();
    drive(1'b0, 4);
`ifdef PWM_CAPTURE_FILTER_EN
    drive(1'b1, 2);
    drive(1'b0, 10);
    drive(1'b1, 2);
    drive(1'b0, 10);
`endif
    for (int i = 0; i < 4; i++) begin
      rt[i] = cyc;
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    drive(1'b0, 20);
    chk_count("f_count", 3);
    for (int i = 1; i < 4; i++)
      expect_ev($sformatf("f%0d", i), rt[i] + LAT, 128, 8, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
